// File: rtl/motor_speed_pi.sv
// motor_speed_pi: sampled shift-gain PI speed regulator with registered duty and 256-step PWM.
// Optional per-update duty slew limiting is enabled with `define SPEED_PI_SLEW_EN.
module motor_speed_pi #(
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned KP_SHIFT   = 1,
  parameter int unsigned KI_SHIFT   = 4,
  parameter int unsigned INT_LIM    = 4095,
  parameter int unsigned SLEW       = 4
) (
  input  logic       cclk,
  input  logic       rstb,
  input  logic       enable,
  input  logic [7:0] setpoint,
  input  logic [7:0] rpm,
  output logic [7:0] duty,
  output logic       pwm,
  output logic       sat,
  output logic       upd
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam int unsigned ERR_W = 9;
  localparam int unsigned INT_W = 16;
  localparam int unsigned U_W   = 17;
  localparam int unsigned PWM_W = 8;

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic signed [U_W-1:0]   LIM_P    = U_W'(INT_LIM);
  localparam logic signed [U_W-1:0]   LIM_N    = -LIM_P;
  localparam logic signed [U_W-1:0]   U_ZERO   = U_W'(0);
  localparam logic signed [U_W-1:0]   U_MAX    = U_W'(255);
  localparam logic signed [ERR_W-1:0] ERR_ZERO = ERR_W'(0);
  localparam logic [7:0]              SLEW_D   = 8'(SLEW);

`ifdef SPEED_PI_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CALC   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic                      latch_c;
  logic                      calc_c;

  logic [CNT_W-1:0]          sample_cnt;
  logic signed [ERR_W-1:0]   err_q;
  logic signed [INT_W-1:0]   integ;

  logic signed [U_W-1:0]     err_ext_c;
  logic signed [U_W-1:0]     p_c;
  logic signed [U_W-1:0]     i_c;
  logic signed [U_W-1:0]     u_c;
  logic signed [U_W-1:0]     sum_c;
  logic signed [U_W-1:0]     sum_lim_c;
  logic signed [INT_W-1:0]   integ_nxt_c;
  logic                      hold_c;
  logic                      sat_c;
  logic [7:0]                u_duty_c;
  logic [7:0]                duty_new_c;

  logic [PWM_W-1:0]          pwm_cnt;
  logic [PWM_W-1:0]          cnt_nxt_c;
  logic [7:0]                duty_cmp;
  logic [7:0]                cmp_nxt_c;
  logic                      pwm_c;

  // Control FSM state register; disable behaves like reset for the loop.
  always_ff @(posedge cclk) begin
    if (rstb || !enable) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt = state;
    latch_c   = 1'b0;
    calc_c    = 1'b0;
    case (state)
      IDLE: begin
        if (sample_cnt == CNT_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        latch_c   = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        calc_c    = 1'b1;
        state_nxt = UPDATE;
      end
      UPDATE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PI law, integrator clamp, anti-windup and output clamp/slew.
  always_comb begin
    err_ext_c = U_W'(err_q);
    p_c       = err_ext_c <<< KP_SHIFT;
    i_c       = U_W'(integ >>> KI_SHIFT);
    u_c       = p_c + i_c;

    sum_c     = U_W'(integ) + err_ext_c;
    sum_lim_c = sum_c;
    if (sum_c > LIM_P) begin
      sum_lim_c = LIM_P;
    end else if (sum_c < LIM_N) begin
      sum_lim_c = LIM_N;
    end
    integ_nxt_c = INT_W'(sum_lim_c);

    hold_c = ((u_c > U_MAX) && (err_q > ERR_ZERO)) ||
             ((u_c < U_ZERO) && (err_q < ERR_ZERO));
    sat_c  = (u_c < U_ZERO) || (u_c > U_MAX);

    if (u_c < U_ZERO) begin
      u_duty_c = 8'd0;
    end else if (u_c > U_MAX) begin
      u_duty_c = 8'd255;
    end else begin
      u_duty_c = u_c[7:0];
    end

    duty_new_c = u_duty_c;
    if (SLEW_ON && (u_duty_c > duty) && ((u_duty_c - duty) > SLEW_D)) begin
      duty_new_c = duty + SLEW_D;
    end else if (SLEW_ON && (duty > u_duty_c) && ((duty - u_duty_c) > SLEW_D)) begin
      duty_new_c = duty - SLEW_D;
    end
  end

  // Sample timer, error latch, integrator and registered duty/status.
  always_ff @(posedge cclk) begin
    if (rstb || !enable) begin
      sample_cnt <= '0;
      err_q      <= '0;
      integ      <= '0;
      duty       <= '0;
      sat        <= 1'b0;
      upd        <= 1'b0;
    end else begin
      sample_cnt <= (sample_cnt == CNT_LAST) ? '0 : sample_cnt + CNT_W'(1);
      upd        <= calc_c;
      if (latch_c) begin
        err_q <= {1'b0, setpoint} - {1'b0, rpm};
      end
      if (calc_c) begin
        duty <= duty_new_c;
        sat  <= sat_c;
        if (!hold_c) integ <= integ_nxt_c;
      end
    end
  end

  // Compare register only reloads at the period boundary so a period never glitches.
  always_comb begin
    cnt_nxt_c = pwm_cnt + PWM_W'(1);
    cmp_nxt_c = duty_cmp;
    if (!enable) begin
      cmp_nxt_c = 8'd0;
    end else if (pwm_cnt == {PWM_W{1'b1}}) begin
      cmp_nxt_c = duty;
    end
    pwm_c = enable && (cnt_nxt_c < cmp_nxt_c);
  end

  // Free-running PWM counter; pwm is registered against the counter value it accompanies.
  always_ff @(posedge cclk) begin
    if (rstb) begin
      pwm_cnt  <= '0;
      duty_cmp <= '0;
      pwm      <= 1'b0;
    end else begin
      pwm_cnt  <= cnt_nxt_c;
      duty_cmp <= cmp_nxt_c;
      pwm      <= pwm_c;
    end
  end

endmodule

// File: tb/tb_motor_speed_pi.sv
// tb_motor_speed_pi: table-driven directed checks of motor_speed_pi with SAMPLE_DIV=16,
// plus hand sequences for anti-windup release, PWM period integrity and disable during CALC.
module tb_motor_speed_pi;

  localparam int unsigned N = 16;

`ifdef SPEED_PI_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  logic       cclk = 1'b0;
  logic       rstb;
  logic       enable;
  logic [7:0] setpoint;
  logic [7:0] rpm;
  logic [7:0] duty;
  logic       pwm;
  logic       sat;
  logic       upd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] sp;
    logic [7:0] rpm;
    int         k;
    logic [7:0] d;
    logic       s;
    logic [7:0] d_slew;
  } vec_t;

  vec_t vecs[12];

  motor_speed_pi #(.SAMPLE_DIV(N)) dut (
    .cclk     (cclk),
    .rstb     (rstb),
    .enable   (enable),
    .setpoint (setpoint),
    .rpm      (rpm),
    .duty     (duty),
    .pwm      (pwm),
    .sat      (sat),
    .upd      (upd)
  );

  always #5 cclk = ~cclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drop enable to clear loop state, apply new inputs, re-enable at a negedge.
  task automatic restart(input logic [7:0] sp, input logic [7:0] r);
    enable   = 1'b0;
    setpoint = sp;
    rpm      = r;
    repeat (2) @(negedge cclk);
    enable = 1'b1;
  endtask

  task automatic wait_upd(input int k, output bit ok);
    int seen;
    seen = 0;
    ok   = 1'b0;
    for (int c = 0; c < k * N + 4 * N; c++) begin
      @(negedge cclk);
      if (upd === 1'b1) begin
        seen++;
        if (seen == k) begin
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic find_rise(output bit ok);
    logic prev;
    prev = pwm;
    ok   = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge cclk);
      if (pwm === 1'b1 && prev === 1'b0) begin
        ok = 1'b1;
        break;
      end
      prev = pwm;
    end
  endtask

  // Counts pwm highs over 256 cycles starting at the current negedge.
  task automatic count_period(input int change_at, output int hi);
    hi = 0;
    for (int c = 0; c < 256; c++) begin
      if (c > 0) @(negedge cclk);
      if (c == change_at) setpoint = 8'd80;
      hi += int'(pwm);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int hi;
    int lat;
    int upd_seen;

    vecs[0]  = '{8'd100, 8'd100, 1,  8'd0,   1'b0, 8'd0};
    vecs[1]  = '{8'd100, 8'd100, 5,  8'd0,   1'b0, 8'd0};
    vecs[2]  = '{8'd100, 8'd90,  1,  8'd20,  1'b0, 8'd4};
    vecs[3]  = '{8'd100, 8'd90,  16, 8'd29,  1'b0, 8'd29};
    vecs[4]  = '{8'd100, 8'd90,  17, 8'd30,  1'b0, 8'd30};
    vecs[5]  = '{8'd255, 8'd0,   1,  8'd255, 1'b1, 8'd4};
    vecs[6]  = '{8'd0,   8'd255, 1,  8'd0,   1'b1, 8'd0};
    vecs[7]  = '{8'd50,  8'd100, 1,  8'd0,   1'b1, 8'd0};
    vecs[8]  = '{8'd200, 8'd100, 1,  8'd200, 1'b0, 8'd4};
    vecs[9]  = '{8'd200, 8'd72,  1,  8'd255, 1'b1, 8'd4};
    vecs[10] = '{8'd200, 8'd73,  1,  8'd254, 1'b0, 8'd4};
    vecs[11] = '{8'd120, 8'd100, 2,  8'd41,  1'b0, 8'd8};

    // Reset held with enable high and a large setpoint.
    rstb = 1'b1; enable = 1'b1; setpoint = 8'd200; rpm = 8'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge cclk);
      check("rst_duty", duty, 0);
      check("rst_pwm",  pwm,  0);
      check("rst_sat",  sat,  0);
      check("rst_upd",  upd,  0);
    end
    rstb = 1'b0;

    // First-update latency from enable rising.
    restart(8'd100, 8'd90);
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge cclk);
      if (upd === 1'b1) begin
        lat = c;
        break;
      end
    end
    check("first_upd_latency", lat, N + 2);

    for (int v = 0; v < 12; v++) begin
      restart(vecs[v].sp, vecs[v].rpm);
      wait_upd(vecs[v].k, ok);
      check($sformatf("vec%0d_timeout", v), ok, 1);
      check($sformatf("vec%0d_duty", v), duty, SLEW_ON ? vecs[v].d_slew : vecs[v].d);
      check($sformatf("vec%0d_sat", v), sat, vecs[v].s);
    end

    // Saturated high: integrator must not wind up, so release to err=0 gives duty 0.
    restart(8'd255, 8'd0);
    wait_upd(3, ok);
    check("aw_timeout", ok, 1);
    check("aw_sat_duty", duty, SLEW_ON ? 12 : 255);
    check("aw_sat_flag", sat, 1);
    rpm = 8'd255;
    wait_upd(1, ok);
    check("aw_release_duty", duty, SLEW_ON ? 8 : 0);
    check("aw_release_sat", sat, 0);

    // Zero duty keeps pwm low.
    restart(8'd100, 8'd100);
    count_period(-1, hi);
    check("pwm_zero_highs", hi, 0);

    // Ramp integ to 1024 with err=64, then err=0 settles u at 64.
    restart(8'd64, 8'd0);
    wait_upd(16, ok);
    check("ramp_timeout", ok, 1);
    rpm = 8'd64;
    wait_upd(20, ok);
    check("settle_timeout", ok, 1);
    check("settle_duty", duty, 64);
    find_rise(ok);
    check("rise1_timeout", ok, 1);
    find_rise(ok);
    check("rise2_timeout", ok, 1);
    count_period(-1, hi);
    check("pwm64_highs", hi, 64);
    find_rise(ok);
    check("rise3_timeout", ok, 1);
    count_period(10, hi);
    check("pwm_midchange_highs", hi, 64);
    check("duty_moved", duty != 8'd64, 1);
    find_rise(ok);
    check("rise4_timeout", ok, 1);
    count_period(-1, hi);
    check("pwm_next_period_grew", hi > 64, 1);

    // Disable while in CALC: computed update must be dropped.
    restart(8'd100, 8'd90);
    wait_upd(1, ok);
    check("dis_timeout", ok, 1);
    check("dis_pre_duty", duty, SLEW_ON ? 4 : 20);
    repeat (N - 1) @(negedge cclk);
    enable = 1'b0;
    @(negedge cclk);
    check("dis_duty", duty, 0);
    check("dis_pwm",  pwm,  0);
    check("dis_upd",  upd,  0);
    upd_seen = 0;
    for (int c = 0; c < 2 * N; c++) begin
      @(negedge cclk);
      upd_seen += int'(upd);
    end
    check("dis_no_upd", upd_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
